// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit pipeline.
//
// Sits between EX/MEM and MEM/WB. Loads/stores (word or byte) go out over a
// registered req/ack handshake with variable latency. Upstream is stalled
// while an access is outstanding, and MEM/WB sees bubbles (REGWrite=0) while
// stalled and on faulted accesses.
//
// Handshake: mem_req_o rises at a clock edge together with stable
// mem_we_o/addr/wdata/be and holds them until the edge at which mem_ack_i is
// sampled high (or the access times out). mem_ack_i is only honoured while
// mem_req_o is high; mem_rdata_i is valid in the same cycle as mem_ack_i.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_*_M, i_ALU_out,
//   i_Store_data              EX/MEM controls, byte address, store data
//   o_*_M, o_ALU_out,
//   o_DMEM_out                write-back controls and data to MEM/WB
//   stall_o                   freezes PC, IF/ID, ID/EX, EX/MEM
//   mem_req_o ... mem_be_o    registered request to data memory
//   mem_rdata_i, mem_ack_i    response from data memory
//   fault_o                   one-cycle pulse in DONE for faulted accesses
//   dbg_state_o               current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module mem_stage #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_MemRead_M,
   input  logic        i_MemWrite_M,
   input  logic        i_Byte_M,
   input  logic        i_Signed_M,
   input  logic        i_REGWrite_M,
   input  logic        i_MEMtoReg_M,
   input  logic [4:0]  i_Write_Reg_M,
   input  logic [15:0] i_ALU_out,
   input  logic [15:0] i_Store_data,
   output logic        o_REGWrite_M,
   output logic        o_MEMtoReg_M,
   output logic [4:0]  o_Write_Reg_M,
   output logic [15:0] o_ALU_out,
   output logic [15:0] o_DMEM_out,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [14:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   output logic [1:0]  mem_be_o,
   input  logic [15:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic        fault_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [15:0] data_q;
   logic        fault_q;

   logic        mem_op;
   logic        bad_op;
   logic [15:0] mem_wdata_d;
   logic [1:0]  mem_be_d;
   logic [7:0]  byte_sel;
   logic        byte_ext;
   logic [15:0] rdata_fmt_d;

   assign mem_op = i_MemRead_M | i_MemWrite_M;
   // Illegal (read and write together) or a word access on an odd address.
   assign bad_op = (i_MemRead_M & i_MemWrite_M) | (~i_Byte_M & i_ALU_out[0]);

   // Byte stores replicate the byte on both lanes; the enable picks the lane.
   assign mem_wdata_d = i_Byte_M ? {i_Store_data[7:0], i_Store_data[7:0]} : i_Store_data;
   assign mem_be_d    = i_Byte_M ? (i_ALU_out[0] ? 2'b10 : 2'b01) : 2'b11;

   // The registered byte enables identify the lane of the outstanding access.
   assign byte_sel    = (mem_be_o == 2'b10) ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
   assign byte_ext    = i_Signed_M & byte_sel[7];
   assign rdata_fmt_d = (mem_be_o == 2'b11) ? mem_rdata_i : {{8{byte_ext}}, byte_sel};

   assign o_MEMtoReg_M  = i_MEMtoReg_M;
   assign o_Write_Reg_M = i_Write_Reg_M;
   assign o_ALU_out     = i_ALU_out;
   assign dbg_state_o   = state_q;

   always_comb begin
      stall_o      = 1'b0;
      o_REGWrite_M = i_REGWrite_M;
      o_DMEM_out   = 16'h0000;
      fault_o      = 1'b0;
      if (rst) begin
         o_REGWrite_M = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mem_op) begin
                  stall_o      = 1'b1;
                  o_REGWrite_M = 1'b0;
               end
            end
            S_BUSY: begin
               stall_o      = 1'b1;
               o_REGWrite_M = 1'b0;
            end
            S_DONE: begin
               o_DMEM_out = data_q;
               fault_o    = fault_q;
               if (fault_q) o_REGWrite_M = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 15'h0000;
         mem_wdata_o <= 16'h0000;
         mem_be_o    <= 2'b00;
         cnt_q       <= 8'h00;
         data_q      <= 16'h0000;
         fault_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mem_op) begin
                  data_q <= 16'h0000;
                  cnt_q  <= 8'h00;
                  if (bad_op) begin
                     fault_q <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= i_MemWrite_M;
                     mem_addr_o  <= i_ALU_out[15:1];
                     mem_wdata_o <= mem_wdata_d;
                     mem_be_o    <= mem_be_d;
                     fault_q     <= 1'b0;
                     state_q     <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               // An ack in the final allowed cycle wins over the timeout.
               if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  if (!mem_we_o) data_q <= rdata_fmt_d;
                  state_q <= S_DONE;
               end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  fault_q   <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_DONE: begin
               fault_q <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_MemRead_M, i_MemWrite_M, i_Byte_M, i_Signed_M;
   logic        i_REGWrite_M, i_MEMtoReg_M;
   logic [4:0]  i_Write_Reg_M;
   logic [15:0] i_ALU_out, i_Store_data;
   logic        o_REGWrite_M, o_MEMtoReg_M;
   logic [4:0]  o_Write_Reg_M;
   logic [15:0] o_ALU_out, o_DMEM_out;
   logic        stall_o, mem_req_o, mem_we_o;
   logic [14:0] mem_addr_o;
   logic [15:0] mem_wdata_o;
   logic [1:0]  mem_be_o;
   logic [15:0] mem_rdata_i;
   logic        mem_ack_i;
   logic        fault_o;
   logic [1:0]  dbg_state_o;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_MemRead_M(i_MemRead_M), .i_MemWrite_M(i_MemWrite_M),
      .i_Byte_M(i_Byte_M), .i_Signed_M(i_Signed_M),
      .i_REGWrite_M(i_REGWrite_M), .i_MEMtoReg_M(i_MEMtoReg_M),
      .i_Write_Reg_M(i_Write_Reg_M), .i_ALU_out(i_ALU_out),
      .i_Store_data(i_Store_data),
      .o_REGWrite_M(o_REGWrite_M), .o_MEMtoReg_M(o_MEMtoReg_M),
      .o_Write_Reg_M(o_Write_Reg_M), .o_ALU_out(o_ALU_out),
      .o_DMEM_out(o_DMEM_out), .stall_o(stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .fault_o(fault_o), .dbg_state_o(dbg_state_o)
   );

   typedef struct {
      logic        rd, wr, byt, sgn, regw, m2r;
      logic [4:0]  rdst;
      logic [15:0] alu, sdata;
   } in_t;

   typedef struct {
      int          stall;
      int          reqs;
      logic        regw;
      logic        fault;
      logic        chk_dmem;
      logic [15:0] dmem;
      logic [14:0] addr;
      logic [1:0]  be;
      logic [15:0] wdata;
      logic        we;
   } exp_t;

   typedef struct {
      in_t         in;
      int          lat;
      logic [15:0] rdata;
      exp_t        e;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic in_t mk_in(input logic rd, input logic wr, input logic byt, input logic sgn,
                                 input logic regw, input logic m2r, input logic [4:0] rdst,
                                 input logic [15:0] alu, input logic [15:0] sdata);
      in_t v;
      v.rd = rd; v.wr = wr; v.byt = byt; v.sgn = sgn; v.regw = regw; v.m2r = m2r;
      v.rdst = rdst; v.alu = alu; v.sdata = sdata;
      return v;
   endfunction

   function automatic exp_t mk_exp(input int stall, input int reqs, input logic regw,
                                   input logic fault, input logic chk, input logic [15:0] dmem,
                                   input logic [14:0] addr, input logic [1:0] be,
                                   input logic [15:0] wdata, input logic we);
      exp_t e;
      e.stall = stall; e.reqs = reqs; e.regw = regw; e.fault = fault; e.chk_dmem = chk;
      e.dmem = dmem; e.addr = addr; e.be = be; e.wdata = wdata; e.we = we;
      return e;
   endfunction

   // Reference model: derives the expected transaction from the rules with
   // plain arithmetic (latency, lanes, extension).
   function automatic exp_t model(input in_t v, input int lat, input logic [15:0] rdata);
      exp_t e;
      int   b;
      int   sh;
      e = mk_exp(0, 0, v.regw, 1'b0, 1'b0, 16'h0, 15'(v.alu / 2), 2'b11, v.sdata, v.wr);
      if (v.byt) begin
         e.be    = (v.alu % 2 == 1) ? 2'b10 : 2'b01;
         e.wdata = 16'((v.sdata % 256) * 257);
      end
      if (!(v.rd || v.wr)) begin
         e.chk_dmem = 1'b1;
      end else if ((v.rd && v.wr) || (!v.byt && v.alu % 2 == 1)) begin
         e.stall = 1; e.regw = 1'b0; e.fault = 1'b1;
      end else if (lat < TO) begin
         e.stall = lat + 2; e.reqs = lat + 1;
         if (v.rd) begin
            e.chk_dmem = 1'b1;
            if (v.byt) begin
               sh = (v.alu % 2 == 1) ? 256 : 1;
               b  = (int'(rdata) / sh) % 256;
               if (v.sgn && b >= 128) b = b + 65280;
               e.dmem = 16'(b);
            end else begin
               e.dmem = rdata;
            end
         end
      end else begin
         e.stall = TO + 1; e.reqs = TO; e.regw = 1'b0; e.fault = 1'b1;
      end
      return e;
   endfunction

   task automatic set_in(input in_t v);
      i_MemRead_M = v.rd; i_MemWrite_M = v.wr; i_Byte_M = v.byt; i_Signed_M = v.sgn;
      i_REGWrite_M = v.regw; i_MEMtoReg_M = v.m2r; i_Write_Reg_M = v.rdst;
      i_ALU_out = v.alu; i_Store_data = v.sdata;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
   task automatic run_op(input string tag, input in_t v, input int lat,
                         input logic [15:0] rdata, input exp_t e);
      int   stall_cnt = 0;
      int   req_cnt = 0;
      logic done = 1'b0;
      logic stable_bad = 1'b0;
      logic bubble_bad = 1'b0;
      set_in(v);
      mem_ack_i = 1'b0;
      mem_rdata_i = 16'h0000;
      if (e.chk_dmem) exp_q.push_back(e.dmem);
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         mem_ack_i = 1'b0;
         if (mem_req_o) begin
            if (mem_addr_o !== e.addr || mem_be_o !== e.be ||
                mem_wdata_o !== e.wdata || mem_we_o !== e.we) stable_bad = 1'b1;
            if (req_cnt == lat) begin
               mem_ack_i = 1'b1;
               mem_rdata_i = rdata;
            end
            req_cnt++;
         end
         @(negedge clk);
         if (stall_o) begin
            stall_cnt++;
            if (o_REGWrite_M !== 1'b0 || fault_o !== 1'b0) bubble_bad = 1'b1;
         end else begin
            done = 1'b1;
            check({tag, " regwrite"}, 32'(o_REGWrite_M), 32'(e.regw));
            check({tag, " fault"}, 32'(fault_o), 32'(e.fault));
            check({tag, " alu_out"}, 32'(o_ALU_out), 32'(v.alu));
            check({tag, " wreg/m2r"}, {26'h0, o_MEMtoReg_M, o_Write_Reg_M}, {26'h0, v.m2r, v.rdst});
            if (e.chk_dmem) check({tag, " dmem"}, 32'(o_DMEM_out), 32'(exp_q.pop_front()));
         end
      end
      check({tag, " completes"}, 32'(done), 32'd1);
      check({tag, " stall cycles"}, 32'(stall_cnt), 32'(e.stall));
      check({tag, " req cycles"}, 32'(req_cnt), 32'(e.reqs));
      if (e.reqs > 0) check({tag, " req fields"}, 32'(stable_bad), 32'd0);
      check({tag, " bubbles"}, 32'(bubble_bad), 32'd0);
      @(posedge clk); #1;
      mem_ack_i = 1'b0;
   endtask

   vec_t tbl[10];
   in_t  nop;

   initial begin
      nop = mk_in(0, 0, 0, 0, 0, 0, 5'd0, 16'h0, 16'h0);
      // Table: inputs, ack latency, read data, expected outcome.
      tbl[0] = '{mk_in(0,0,0,0,1,0,5'd5,16'h1234,16'h0), 0, 16'h0,
                 mk_exp(0,0,1,0,1,16'h0000,15'h0,2'b00,16'h0,0)};
      tbl[1] = '{mk_in(1,0,0,0,1,1,5'd3,16'h0010,16'h0), 3, 16'hBEEF,
                 mk_exp(5,4,1,0,1,16'hBEEF,15'h0008,2'b11,16'h0,0)};
      tbl[2] = '{mk_in(1,0,1,1,1,1,5'd4,16'h0021,16'h0), 1, 16'h80FF,
                 mk_exp(3,2,1,0,1,16'hFF80,15'h0010,2'b10,16'h0000,0)};
      tbl[3] = '{mk_in(1,0,1,0,1,1,5'd4,16'h0021,16'h0), 1, 16'h80FF,
                 mk_exp(3,2,1,0,1,16'h0080,15'h0010,2'b10,16'h0000,0)};
      tbl[4] = '{mk_in(0,1,1,0,0,0,5'd0,16'h0003,16'h12AB), 0, 16'h0,
                 mk_exp(2,1,0,0,0,16'h0,15'h0001,2'b10,16'hABAB,1)};
      tbl[5] = '{mk_in(1,0,0,0,1,1,5'd7,16'h0005,16'h0), 0, 16'h0,
                 mk_exp(1,0,0,1,0,16'h0,15'h0,2'b00,16'h0,0)};
      tbl[6] = '{mk_in(1,0,0,0,1,1,5'd8,16'h0040,16'h0), 99, 16'h0,
                 mk_exp(5,4,0,1,0,16'h0,15'h0020,2'b11,16'h0,0)};
      tbl[7] = '{mk_in(1,1,0,0,1,0,5'd9,16'h0100,16'h5555), 0, 16'h0,
                 mk_exp(1,0,0,1,0,16'h0,15'h0,2'b00,16'h0,0)};
      tbl[8] = '{mk_in(1,0,1,1,1,1,5'd10,16'h0022,16'h0), 2, 16'h7F80,
                 mk_exp(4,3,1,0,1,16'hFF80,15'h0011,2'b01,16'h0000,0)};
      tbl[9] = '{mk_in(0,1,0,0,0,0,5'd0,16'h0100,16'hCAFE), 3, 16'h0,
                 mk_exp(5,4,0,0,0,16'h0,15'h0080,2'b11,16'hCAFE,1)};

      // Clock/reset with a write-back request present to check suppression.
      rst = 1'b1;
      mem_ack_i = 1'b0;
      mem_rdata_i = 16'h0;
      set_in(mk_in(1,0,0,0,1,1,5'd1,16'h0002,16'h0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset stall", 32'(stall_o), 32'd0);
      check("reset regwrite", 32'(o_REGWrite_M), 32'd0);
      check("reset fault", 32'(fault_o), 32'd0);
      check("reset state", 32'(dbg_state_o), 32'd0);
      check("reset mem regs", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, 13'h0},
            32'h0);
      check("reset wdata", 32'(mem_wdata_o), 32'd0);
      set_in(nop);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].in, tbl[i].lat, tbl[i].rdata, tbl[i].e);
      end

      // Reset in the middle of an outstanding load, followed by a late ack.
      set_in(mk_in(1,0,0,0,1,1,5'd2,16'h0030,16'h0));
      @(posedge clk); #1;
      check("rstbusy req up", 32'(mem_req_o), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rstbusy stall in rst", 32'(stall_o), 32'd0);
      @(posedge clk); #1;
      mem_ack_i = 1'b1;
      mem_rdata_i = 16'h1111;
      check("rstbusy req dropped", 32'(mem_req_o), 32'd0);
      check("rstbusy state idle", 32'(dbg_state_o), 32'd0);
      @(negedge clk);
      check("rstbusy stall", 32'(stall_o), 32'd0);
      set_in(nop);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("late ack ignored req", 32'(mem_req_o), 32'd0);
      check("late ack ignored state", 32'(dbg_state_o), 32'd0);
      mem_ack_i = 1'b0;
      @(posedge clk); #1;

      // Randomized instruction stream against the reference model.
      for (int i = 0; i < 80; i++) begin
         in_t v;
         int  kind;
         int  lat;
         logic [15:0] rd;
         kind = $urandom_range(0, 9);
         v = mk_in(kind >= 2 && kind <= 5 || kind == 9, kind >= 6,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), 16'($urandom), 16'($urandom));
         lat = $urandom_range(0, 5);
         rd  = 16'($urandom);
         run_op($sformatf("rnd%0d", i), v, lat, rd, model(v, lat, rd));
      end

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
